mem_arbiter: RTL
================

# mem_arbiter

Merges the pipeline's separate instruction and data memory ports onto one multi-cycle memory port. Sits directly downstream of the `cpu` top, between its `imem_*`/`dmem_*` ports and the single-port memory model or cache. Each side holds at most one outstanding request. Requests are captured into per-side slots, arbitrated, serialized to memory, and returned with a one-cycle response pulse.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `imem_addr` in 32: fetch address, word-aligned.
- `imem_rmask` in 4: non-zero marks a fetch request this cycle.
- `imem_rdata` out 32: fetch data, valid while `imem_resp`=1.
- `imem_resp` out 1: one-cycle fetch completion pulse.
- `dmem_addr` in 32: data address, word-aligned.
- `dmem_rmask` in 4: non-zero marks a load request.
- `dmem_wmask` in 4: non-zero marks a store request.
- `dmem_wdata` in 32: store data.
- `dmem_rdata` out 32: load data, valid while `dmem_resp`=1.
- `dmem_resp` out 1: one-cycle load/store completion pulse.
- `mem_addr` out 32: memory request address.
- `mem_rmask` out 4: memory read mask; non-zero means a read is in flight.
- `mem_wmask` out 4: memory write mask; non-zero means a write is in flight.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid with `mem_resp`.
- `mem_resp` in 1: memory completion, one cycle per request.

## Operation
- **Capture.** A side has a request in any cycle where its mask is non-zero (`imem_rmask`, or `dmem_rmask|dmem_wmask`). The request {addr, rmask, wmask, wdata} is latched into that side's slot at the clock edge.
  - The CPU may drop the request after one cycle.
  - A new request on a side whose slot is occupied and not completing this cycle is a protocol violation. The request is dropped, and a simulation assertion fires.
- **Mask conflicts.** `dmem_rmask` and `dmem_wmask` both non-zero is illegal; the arbiter asserts. The rmask reaching the data slot is ignored, so it is treated as a write.
- **States:** IDLE, SERVE_I, SERVE_D.
  - IDLE: data slot full → SERVE_D. Else instruction slot full → SERVE_I. Else stay in IDLE.
  - Arbitration tie (both slots full when choosing): grant the side not granted last. The `last_grant` register resets to I, so the first tie goes to D.
  - SERVE_x with `mem_resp`=1: return the response; clear slot x; choose the next state by the IDLE rules. The other slot's content is considered, including a capture landing this same edge.
  - SERVE_x with `mem_resp`=0: hold.
- **Memory outputs.** Registered. They are loaded from the granted slot on entry to SERVE_x and held constant until `mem_resp`. In IDLE they are driven with all masks 0.
  - The data side passes `dmem_rmask`/`dmem_wmask`/`dmem_wdata` through unchanged.
  - The instruction side drives `mem_wmask`=0.
- **Response.** Registered.
  - On `mem_resp` in SERVE_I: next cycle `imem_resp`=1 and `imem_rdata`=`mem_rdata`.
  - On `mem_resp` in SERVE_D: next cycle `dmem_resp`=1. `dmem_rdata` returns `mem_rdata` for reads; for writes it holds its previous value.
  - `*_rdata` holds its value between responses.
- `mem_resp` in IDLE is ignored.

## Timing
- **Reset values:** all `mem_*` outputs 0, `imem_resp`=`dmem_resp`=0, `imem_rdata`=`dmem_rdata`=0, both slots empty, state IDLE, `last_grant`=I.
- **Minimum latency:** request in cycle T → memory outputs valid at T+1 → `mem_resp` at T+1 at earliest → CPU response pulse at T+2.
- **Back-to-back service:** the other side's memory request is presented in the cycle right after `mem_resp`, with no idle bubble.
- **Capture/completion overlap:** a new request on side x in the same cycle as `imem_resp`/`dmem_resp` for x is legal and is captured.
- **Reset mid-transaction:** in-flight and pending requests are abandoned and no response is generated. A late `mem_resp` after reset is ignored because the block is in IDLE.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}.
  - `mem_req_t` struct {addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0]}.
  - `grant_t` enum {GNT_I, GNT_D}.
- Sub-module `mem_req_slot`: a one-entry request latch with valid, capture, and clear, where clear-and-capture in the same cycle yields valid=1 with the new content. It is instantiated twice.

## Test plan
- **Single fetch.** `imem_addr`=0x60000000, rmask=0xF at T; memory responds one cycle after request with 0x00000013 → `mem_addr`=0x60000000 at T+1; `imem_resp`=1 with rdata 0x00000013 at T+2.
- **Simultaneous requests.** Fetch 0x60000004 and store 0x1000 (wmask 0x3, wdata 0xBEEF) at T → the store is served first (`mem_wmask`=0x3). The fetch is presented the cycle after `mem_resp`. `dmem_resp` pulses, then `imem_resp`.
- **Multi-cycle memory.** Memory latency 5 cycles on a load from 0x2000 → `mem_rmask` is held constant for 5 cycles; exactly one `dmem_resp` pulse.
- **Alternation under contention.** Both sides re-request every cycle their response arrives, for 6 transactions → grants alternate D, I, D, I, D, I.
- **Reset mid-operation.** Assert `rst` while in SERVE_D with `mem_resp` pending; drive `mem_resp`=1 the cycle after reset deasserts → no `dmem_resp`, all `mem_*` masks 0, state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   mem_req_t   : one captured memory request
//   grant_t     : which side was granted most recently
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request latch.
//   clk, rst : clock, synchronous active-high reset
//   capture  : load req_in, set valid (wins over clear)
//   clear    : drop the held request
//   req_in   : request to capture
//   valid    : slot holds a request
//   req      : held request
module mem_req_slot
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  logic     clear,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the CPU instruction and data ports onto one multi-cycle memory port.
//   clk, rst                         : clock, synchronous active-high reset
//   imem_addr/imem_rmask             : fetch request (rmask != 0 marks a request)
//   imem_rdata/imem_resp             : fetch data and one-cycle completion pulse
//   dmem_addr/rmask/wmask/wdata      : load/store request
//   dmem_rdata/dmem_resp             : load data and one-cycle completion pulse
//   mem_addr/rmask/wmask/wdata       : registered request to memory
//   mem_rdata/mem_resp               : memory read data and completion
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  arb_state_t state, state_n;
  grant_t     last_grant, grant_n;
  mem_req_t   mem_q;

  logic       i_has_req, d_has_req;
  logic       i_valid, d_valid;
  logic       i_clear, d_clear;
  logic       i_capture, d_capture;
  logic       i_avail, d_avail;
  logic       decide, load;
  mem_req_t   i_in, d_in, i_req, d_req, i_eff, d_eff;

  assign i_has_req = |imem_rmask;
  assign d_has_req = (|dmem_rmask) | (|dmem_wmask);

  assign i_in = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  // A store with a stray rmask is treated purely as a store.
  assign d_in = '{addr: dmem_addr, rmask: ((|dmem_wmask) ? 4'h0 : dmem_rmask),
                  wmask: dmem_wmask, wdata: dmem_wdata};

  mem_req_slot u_slot_i (
    .clk    (clk),
    .rst    (rst),
    .capture(i_capture),
    .clear  (i_clear),
    .req_in (i_in),
    .valid  (i_valid),
    .req    (i_req)
  );

  mem_req_slot u_slot_d (
    .clk    (clk),
    .rst    (rst),
    .capture(d_capture),
    .clear  (d_clear),
    .req_in (d_in),
    .valid  (d_valid),
    .req    (d_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_I;
    end else begin
      state      <= state_n;
      last_grant <= grant_n;
    end
  end

  // Arbitration looks through the slots: a request captured on this edge
  // is already eligible, so the memory port is loaded with zero bubble.
  always_comb begin
    i_clear   = (state == SERVE_I) && mem_resp;
    d_clear   = (state == SERVE_D) && mem_resp;
    i_capture = i_has_req && (!i_valid || i_clear);
    d_capture = d_has_req && (!d_valid || d_clear);
    i_avail   = i_capture || (i_valid && !i_clear);
    d_avail   = d_capture || (d_valid && !d_clear);
    i_eff     = i_capture ? i_in : i_req;
    d_eff     = d_capture ? d_in : d_req;
    decide    = (state == IDLE) || mem_resp;
    state_n   = state;
    grant_n   = last_grant;
    load      = 1'b0;
    if (decide) begin
      state_n = IDLE;
      if (d_avail && !(i_avail && last_grant == GNT_D)) begin
        state_n = SERVE_D;
        grant_n = GNT_D;
        load    = 1'b1;
      end else if (i_avail) begin
        state_n = SERVE_I;
        grant_n = GNT_I;
        load    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      imem_resp  <= 1'b0;
      dmem_resp  <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      if (decide) begin
        if (load) mem_q <= (grant_n == GNT_D) ? d_eff : i_eff;
        else      mem_q <= '0;
      end
      imem_resp <= i_clear;
      dmem_resp <= d_clear;
      if (i_clear) imem_rdata <= mem_rdata;
      if (d_clear && (|mem_q.rmask)) dmem_rdata <= mem_rdata;
    end
  end

  assign mem_addr  = mem_q.addr;
  assign mem_rmask = mem_q.rmask;
  assign mem_wmask = mem_q.wmask;
  assign mem_wdata = mem_q.wdata;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_has_req && i_valid && !i_clear))
        else $error("mem_arbiter: fetch request dropped, slot busy");
      assert (!(d_has_req && d_valid && !d_clear))
        else $error("mem_arbiter: data request dropped, slot busy");
      assert (!((|dmem_rmask) && (|dmem_wmask)))
        else $error("mem_arbiter: dmem_rmask and dmem_wmask both set");
    end
  end
`endif

endmodule
